cadd_arbiter: RTL and testbench
===============================

CADD_ARBITER -- requirements
Module: cadd_arbiter

Interface
REQ-001 Parameter LAT, default 4: register stages of the shared complex FP adder, counted from its registered operand inputs to its add_c_* outputs; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-requester request; bit i high means requester i presents valid operands.
REQ-005 req_a_re, req_b_re, req_a_img, req_b_img  input  128 each  packed operands; requester i occupies bits [32i+31:32i]; IEEE-754 single precision.
REQ-006 gnt  output  4  one-hot or zero; gnt[i] high means requester i's operands are captured at this clock edge.
REQ-007 add_a_re, add_b_re, add_a_img, add_b_img  output  32 each  registered operands driven to the shared complex adder.
REQ-008 add_c_re, add_c_img  input  32 each  results returned by the shared complex adder.
REQ-009 res_valid  output  4  one-hot or zero; bit i marks the current res_re/res_img as belonging to requester i.
REQ-010 res_re, res_img  output  32 each  results broadcast to all requesters; equal to add_c_re/add_c_img.
REQ-011 issue_cnt  output  16  issued-operation count; present only when CADD_ARB_CNT_EN is defined.

Function
REQ-012 gnt SHALL be combinational from req and the round-robin pointer ptr, a 2-bit register.
- Winner is the first set bit of req, searching ptr, ptr+1, ... mod 4.
- At most one gnt bit is high.
REQ-013 On a clock edge with a grant to i:
- add_a_re/add_b_re/add_a_img/add_b_img load requester i's operand slices.
- ptr becomes (i+1) mod 4.
REQ-014 On a clock edge with req == 0:
- No grant is issued.
- ptr and the operand registers hold.
- An idle (valid=0) tag enters the tag pipeline.
REQ-015 A requester SHALL hold req and its operands stable until it observes its gnt bit high; deasserting req before grant is permitted and withdraws the request with no side effect.
REQ-016 A tag pipeline of depth LAT+1 SHALL carry {valid, 2-bit requester index} for each issue slot, advancing every cycle with no stall.
REQ-017 Latency: a grant in cycle t SHALL produce res_valid[i]=1 in cycle t+1+LAT, and only in that cycle.
REQ-018 Throughput: one issue per cycle; a requester with req held continuously is granted at least once every 4 cycles.
REQ-019 Back-to-back grants to different requesters SHALL return results in grant order, each in its own cycle.
REQ-020 res_re/res_img SHALL pass add_c_re/add_c_img through combinationally; they are meaningful only when res_valid is nonzero.

Reset
REQ-021 While rst is high at a clock edge, the following SHALL be cleared:
- ptr = 0.
- All tag-pipeline valid bits = 0.
- Operand registers = 0x00000000.
- issue_cnt = 0 when present.
REQ-022 During a reset cycle, gnt SHALL be 4'b0000 regardless of req.
REQ-023 Operations in flight when reset asserts SHALL be discarded: res_valid stays 0 for the next LAT+1 cycles after rst deasserts unless new grants occur.
REQ-024 The first grant after reset SHALL go to the lowest-indexed active requester, starting from index 0.

Configuration
REQ-025 Macro CADD_ARB_CNT_EN.
- Defined: issue_cnt increments by 1 on every clock edge with a grant and wraps from 0xFFFF to 0x0000.
- Undefined: the issue_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-026 The bench SHALL cover these directed scenarios (LAT=4; the bench models the adder as a 4-stage pipelined complex FP adder):
- Single request: req=4'b0001, a_re=0x3F800000 (1.0), b_re=0x40000000 (2.0), a_img=b_img=0x3F800000; gnt=4'b0001 in cycle 0 -> res_valid=4'b0001 in cycle 5 with res_re=0x40400000 (3.0), res_img=0x40000000 (2.0).
- Full contention: req=4'b1111 held for 8 cycles after reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; res_valid follows the same sequence starting in cycle 5.
- Sparse contention: req=4'b1010, ptr=0 -> grants alternate 0010, 1000, 0010; requesters 0 and 2 are never granted.
- Idle gap: a grant in cycle 0, req=0 in cycles 1-3, a grant in cycle 4 -> res_valid is nonzero only in cycles 5 and 9.
- Reset mid-flight: grants in cycles 0-2, rst high in cycle 3 -> res_valid stays 0 through cycle 8 and ptr=0 afterwards.
- With CADD_ARB_CNT_EN: 65537 grants -> issue_cnt=0x0001.

Source files
------------

// File: rtl/cadd_arbiter.sv
// cadd_arbiter: round-robin arbiter that shares one pipelined complex FP adder among four
// requesters. Winning operands are registered and driven to the adder. A tag pipeline tracks
// which requester owns each issue slot, so each result can be marked with its owner when it
// returns.
//
// Parameters:
//   LAT        adder register stages from the registered operands to add_c_* (1..16)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req[3:0]                 per-requester request
//   req_{a,b}_{re,img}       packed operands, requester i at bits [32i+31:32i]
//   gnt[3:0]                 one-hot grant (combinational), zero during reset
//   add_{a,b}_{re,img}       registered operands to the shared adder
//   add_c_{re,img}           adder results
//   res_valid[3:0]           one-hot owner of the current result
//   res_re, res_img          results broadcast to all requesters
//   issue_cnt[15:0]          wrapping issue counter, present only with CADD_ARB_CNT_EN
module cadd_arbiter #(
  parameter int unsigned LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] req_a_re,
  input  logic [127:0] req_b_re,
  input  logic [127:0] req_a_img,
  input  logic [127:0] req_b_img,
  output logic [3:0]   gnt,
  output logic [31:0]  add_a_re,
  output logic [31:0]  add_b_re,
  output logic [31:0]  add_a_img,
  output logic [31:0]  add_b_img,
  input  logic [31:0]  add_c_re,
  input  logic [31:0]  add_c_img,
`ifdef CADD_ARB_CNT_EN
  output logic [15:0]  issue_cnt,
`endif
  output logic [3:0]   res_valid,
  output logic [31:0]  res_re,
  output logic [31:0]  res_img
);

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } tag_t;

  logic [1:0] ptr_q;
  logic       gnt_any;
  logic [1:0] gnt_idx;
  tag_t       tag_q [LAT+1];

  // Search starts at ptr and wraps; the first active request wins.
  always_comb begin
    logic [1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        cand = ptr_q + 2'(k);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    gnt = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= 2'd0;
      add_a_re  <= 32'h0;
      add_b_re  <= 32'h0;
      add_a_img <= 32'h0;
      add_b_img <= 32'h0;
    end else if (gnt_any) begin
      ptr_q     <= gnt_idx + 2'd1;
      add_a_re  <= req_a_re[{gnt_idx, 5'd0} +: 32];
      add_b_re  <= req_b_re[{gnt_idx, 5'd0} +: 32];
      add_a_img <= req_a_img[{gnt_idx, 5'd0} +: 32];
      add_b_img <= req_b_img[{gnt_idx, 5'd0} +: 32];
    end
  end

  // Stage 0 lines up with the operand registers; stage LAT lines up with add_c_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: gnt_any, idx: gnt_idx};
      for (int unsigned i = 1; i <= LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    res_valid = 4'b0000;
    if (tag_q[LAT].valid) begin
      res_valid = 4'b0001 << tag_q[LAT].idx;
    end
  end

  assign res_re  = add_c_re;
  assign res_img = add_c_img;

`ifdef CADD_ARB_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'h0;
    end else if (gnt_any) begin
      cnt_q <= cnt_q + 16'h1;
    end
  end

  assign issue_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cadd_arbiter.sv
// tb_cadd_arbiter: directed bench for cadd_arbiter (LAT=4). The shared adder is modelled as
// a 4-stage pipeline computing fp32 sums of positive operands. A per-cycle table of
// {rst, req, expected gnt, expected res_valid} is applied in order. Result data are checked
// against hand-computed sums for each requester. Define CADD_ARB_CNT_EN to run the counter
// wrap test.
module tb_cadd_arbiter;

  localparam int unsigned LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_a_re, req_b_re, req_a_img, req_b_img;
  logic [3:0]   gnt;
  logic [31:0]  add_a_re, add_b_re, add_a_img, add_b_img;
  logic [31:0]  add_c_re, add_c_img;
  logic [3:0]   res_valid;
  logic [31:0]  res_re, res_img;
`ifdef CADD_ARB_CNT_EN
  logic [15:0]  issue_cnt;
`endif

  int tests = 0;
  int fails = 0;

  cadd_arbiter #(.LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a_re  (req_a_re),
    .req_b_re  (req_b_re),
    .req_a_img (req_a_img),
    .req_b_img (req_b_img),
    .gnt       (gnt),
    .add_a_re  (add_a_re),
    .add_b_re  (add_b_re),
    .add_a_img (add_a_img),
    .add_b_img (add_b_img),
    .add_c_re  (add_c_re),
    .add_c_img (add_c_img),
`ifdef CADD_ARB_CNT_EN
    .issue_cnt (issue_cnt),
`endif
    .res_valid (res_valid),
    .res_re    (res_re),
    .res_img   (res_img)
  );

  always #5 clk = ~clk;

  // fp32 add, positive normal operands only; enough for the directed values used here.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb, d;
    logic [24:0] ma, mb, s;
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    if (b[30:23] > a[30:23]) begin
      ea = b[30:23]; eb = a[30:23]; ma = {2'b01, b[22:0]}; mb = {2'b01, a[22:0]};
    end else begin
      ea = a[30:23]; eb = b[30:23]; ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
    end
    d = ea - eb;
    s = ma + (mb >> d);
    if (s[24]) begin
      s  = s >> 1;
      ea = ea + 8'd1;
    end
    return {1'b0, ea, s[22:0]};
  endfunction

  logic [63:0] st [LAT];
  always @(posedge clk) begin
    st[0] <= {fadd(add_a_re, add_b_re), fadd(add_a_img, add_b_img)};
    for (int k = 1; k < int'(LAT); k++) st[k] <= st[k-1];
  end
  assign add_c_re  = st[LAT-1][63:32];
  assign add_c_img = st[LAT-1][31:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] rv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                     input logic [3:0] v);
    vec_t e;
    e.rst = r; e.req = q; e.gnt = g; e.rv = v;
    vecs.push_back(e);
  endtask

  // Expected sums per requester (hand-computed).
  logic [31:0] exp_re [4];
  logic [31:0] exp_im [4];

  initial begin
    // Requester operands: r0 1+2 / 1+1, r1 2+2 / 1+2, r2 4+4 / 2+4, r3 1+4 / 4+4.
    req_a_re  = {32'h3F800000, 32'h40800000, 32'h40000000, 32'h3F800000};
    req_b_re  = {32'h40800000, 32'h40800000, 32'h40000000, 32'h40000000};
    req_a_img = {32'h40800000, 32'h40000000, 32'h3F800000, 32'h3F800000};
    req_b_img = {32'h40800000, 32'h40800000, 32'h40000000, 32'h3F800000};
    exp_re[0] = 32'h40400000; exp_im[0] = 32'h40000000;
    exp_re[1] = 32'h40800000; exp_im[1] = 32'h40400000;
    exp_re[2] = 32'h41000000; exp_im[2] = 32'h40C00000;
    exp_re[3] = 32'h40A00000; exp_im[3] = 32'h41000000;

    // Single request: grant at v0, result at v5.
    add(0, 4'b0001, 4'b0001, 4'b0000);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0001);
    // Reset (req ignored), then full contention for 8 cycles.
    add(1, 4'b1111, 4'b0000, 4'b0000);
    add(0, 4'b1111, 4'b0001, 4'b0000);
    add(0, 4'b1111, 4'b0010, 4'b0000);
    add(0, 4'b1111, 4'b0100, 4'b0000);
    add(0, 4'b1111, 4'b1000, 4'b0000);
    add(0, 4'b1111, 4'b0001, 4'b0000);
    add(0, 4'b1111, 4'b0010, 4'b0001);
    add(0, 4'b1111, 4'b0100, 4'b0010);
    add(0, 4'b1111, 4'b1000, 4'b0100);
    add(0, 4'b0000, 4'b0000, 4'b1000);
    add(0, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'b0000, 4'b0000, 4'b0010);
    add(0, 4'b0000, 4'b0000, 4'b0100);
    add(0, 4'b0000, 4'b0000, 4'b1000);
    add(0, 4'b0000, 4'b0000, 4'b0000);
    // Sparse contention from ptr=0.
    add(0, 4'b1010, 4'b0010, 4'b0000);
    add(0, 4'b1010, 4'b1000, 4'b0000);
    add(0, 4'b1010, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0010);
    add(0, 4'b0000, 4'b0000, 4'b1000);
    add(0, 4'b0000, 4'b0000, 4'b0010);
    add(0, 4'b0000, 4'b0000, 4'b0000);
    // Idle gap: grants at g0 and g0+4.
    add(0, 4'b0100, 4'b0100, 4'b0000);
    for (int i = 0; i < 3; i++) add(0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b1000, 4'b1000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0100);
    for (int i = 0; i < 3; i++) add(0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b1000);
    add(0, 4'b0000, 4'b0000, 4'b0000);
    // Reset mid-flight: three grants, reset, nothing returns, ptr back at 0.
    add(0, 4'b0001, 4'b0001, 4'b0000);
    add(0, 4'b0010, 4'b0010, 4'b0000);
    add(0, 4'b0100, 4'b0100, 4'b0000);
    add(1, 4'b1111, 4'b0000, 4'b0000);
    for (int i = 0; i < 6; i++) add(0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b1010, 4'b0010, 4'b0000);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0010);
    add(0, 4'b0000, 4'b0000, 4'b0000);

    // Initial reset.
    rst = 1'b1;
    req = 4'b1111;
    @(posedge clk); #1;
    chk("gnt_during_reset", {28'h0, gnt}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'b0000;
    #1;
    chk("reset_add_a_re", add_a_re, 32'h0);
    chk("reset_add_b_re", add_b_re, 32'h0);
    chk("reset_add_a_img", add_a_img, 32'h0);
    chk("reset_add_b_img", add_b_img, 32'h0);
    chk("reset_res_valid", {28'h0, res_valid}, 32'h0);
    chk("reset_gnt_idle", {28'h0, gnt}, 32'h0);

    // Table-driven per-cycle checks.
    foreach (vecs[n]) begin
      rst = vecs[n].rst;
      req = vecs[n].req;
      #1;
      chk($sformatf("v%0d_gnt", n), {28'h0, gnt}, {28'h0, vecs[n].gnt});
      chk($sformatf("v%0d_res_valid", n), {28'h0, res_valid}, {28'h0, vecs[n].rv});
      for (int j = 0; j < 4; j++) begin
        if (vecs[n].rv[j]) begin
          chk($sformatf("v%0d_res_re", n), res_re, exp_re[j]);
          chk($sformatf("v%0d_res_img", n), res_img, exp_im[j]);
        end
      end
      @(posedge clk); #1;
      if (n == 0) begin
        chk("v0_add_a_re", add_a_re, 32'h3F800000);
        chk("v0_add_b_re", add_b_re, 32'h40000000);
      end
    end

`ifdef CADD_ARB_CNT_EN
    rst = 1'b1;
    req = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("cnt_reset", {16'h0, issue_cnt}, 32'h0);
    req = 4'b0001;
    for (int i = 0; i < 65537; i++) @(posedge clk);
    #1;
    req = 4'b0000;
    chk("cnt_wrap", {16'h0, issue_cnt}, 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
